// File: rtl/nios_system_nios_cpu_debug_jtag_master.sv
// ----------------------------------------------------------------------------
// nios_system_nios_cpu_debug_jtag_master
//
// Drives a virtual-JTAG style debug slave from a simple command/response
// handshake. Each accepted command runs one scan of 42 tck periods:
// UIR, CDR, 38 x SHIFT, UDR, RTI. The captured DR is then presented on the
// response port until it is consumed.
//
// Parameter
//   TCK_DIV    clk cycles per vji_tck half-period (1..255)
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    synchronous active-low reset
//   cmd_valid  / cmd_ready / cmd_ir[1:0] / cmd_data[37:0]   scan command
//   rsp_valid  / rsp_ready / rsp_data[37:0]                 captured DR
//   vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
//   vji_ir_in[1:0]                                          drive to slave
//   vji_tdo                                                 return from slave
//
// Build option
//   NIOS_DBG_JTAG_MASTER_LOOPBACK_EN  when defined, the shift register
//   captures its own vji_tdi instead of vji_tdo, so rsp_data == cmd_data.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high, tck parked low
// S_UIR   | one tck period with vji_uir high (IR update)
// S_CDR   | one tck period with vji_cdr high (DR capture)
// S_SHIFT | 38 tck periods with vji_sdr high, tdi out / tdo in
// S_UDR   | one tck period with vji_udr high (DR update)
// S_RTI   | one tck period with vji_rti high
// S_RSP   | rsp_valid high, holding rsp_data until rsp_ready
// ----------------------------------------------------------------------------
module nios_system_nios_cpu_debug_jtag_master #(
   parameter int unsigned TCK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_ir,
   input  logic [37:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [37:0] rsp_data,
   output logic        vji_tck,
   output logic        vji_tdi,
   output logic        vji_uir,
   output logic        vji_cdr,
   output logic        vji_sdr,
   output logic        vji_udr,
   output logic        vji_rti,
   output logic [1:0]  vji_ir_in,
   input  logic        vji_tdo
);

   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RSP
   } state_t;

   localparam logic [7:0] DIV_LOAD = 8'(TCK_DIV - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_div;
   logic        r_tck;
   logic        r_tdi;
   logic        r_cmd_ready;
   logic [5:0]  r_bit;
   logic [37:0] r_sr;
   logic [1:0]  r_ir;

   logic w_accept;
   logic w_active;
   logic w_tc;
   logic w_rise;
   logic w_fall;
   logic w_sample;

   assign w_accept = cmd_valid & r_cmd_ready;
   assign w_active = (r_state != S_IDLE) && (r_state != S_RSP);
   assign w_tc     = (r_div == 8'd0);
   assign w_rise   = w_active & w_tc & ~r_tck;
   assign w_fall   = w_active & w_tc &  r_tck;

`ifdef NIOS_DBG_JTAG_MASTER_LOOPBACK_EN
   assign w_sample = r_tdi;
`else
   assign w_sample = vji_tdo;
`endif

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_UIR;
         S_UIR:   if (w_fall) w_state_nxt = S_CDR;
         S_CDR:   if (w_fall) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_fall && (r_bit == 6'd0)) w_state_nxt = S_UDR;
         S_UDR:   if (w_fall) w_state_nxt = S_RTI;
         S_RTI:   if (w_fall) w_state_nxt = S_RSP;
         S_RSP:   if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_div       <= 8'd0;
         r_tck       <= 1'b0;
         r_tdi       <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_bit       <= 6'd0;
         r_sr        <= 38'd0;
         r_ir        <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_ready <= (w_state_nxt == S_IDLE);
         if (w_accept) begin
            r_sr  <= cmd_data;
            r_ir  <= cmd_ir;
            r_div <= DIV_LOAD;
            r_tck <= 1'b0;
            r_tdi <= 1'b0;
         end else if (w_active) begin
            if (w_tc) begin
               r_div <= DIV_LOAD;
               r_tck <= ~r_tck;
            end else begin
               r_div <= r_div - 8'd1;
            end
            if (w_rise && (r_state == S_SHIFT)) begin
               r_sr <= {w_sample, r_sr[37:1]};
            end
            // Falling tck starts a new period: present the next bit, which
            // the previous rising edge has already moved into bit 0.
            if (w_fall) begin
               r_tdi <= (w_state_nxt == S_SHIFT) ? r_sr[0] : 1'b0;
               if (r_state == S_CDR) begin
                  r_bit <= 6'd37;
               end else if (r_state == S_SHIFT) begin
                  r_bit <= r_bit - 6'd1;
               end
            end
         end
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = (r_state == S_RSP);
   assign rsp_data  = r_sr;
   assign vji_tck   = r_tck;
   assign vji_tdi   = r_tdi;
   assign vji_uir   = (r_state == S_UIR);
   assign vji_cdr   = (r_state == S_CDR);
   assign vji_sdr   = (r_state == S_SHIFT);
   assign vji_udr   = (r_state == S_UDR);
   assign vji_rti   = (r_state == S_RTI);
   assign vji_ir_in = r_ir;

endmodule

// File: doc/nios_system_nios_cpu_debug_jtag_master.md
NIOS_SYSTEM_NIOS_CPU_DEBUG_JTAG_MASTER -- requirements
Module: nios_system_nios_cpu_debug_jtag_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, clk cycles per vji_tck half-period; legal range 1..255.
REQ-002 SHALL have clk  input  1  sole clock; all logic rising-edge clk.
REQ-003 SHALL have reset_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have cmd_valid  input  1  scan command present.
REQ-005 SHALL have cmd_ready  output  1  block accepts command.
REQ-006 SHALL have cmd_ir  input  2  virtual IR value for scan.
REQ-007 SHALL have cmd_data  input  38  DR value shifted out, LSB first.
REQ-008 SHALL have rsp_valid  output  1  captured DR available.
REQ-009 SHALL have rsp_ready  input  1  response consumed.
REQ-010 SHALL have rsp_data  output  38  captured vji_tdo bits, first captured in bit 0.
REQ-011 SHALL have vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  output  1 each  virtual JTAG drive toward debug slave.
REQ-012 SHALL have vji_ir_in  output  2  virtual IR toward debug slave.
REQ-013 SHALL have vji_tdo  input  1  serial return from debug slave.

Function
REQ-014 SHALL implement FSM IDLE, UIR, CDR, SHIFT, UDR, RTI, RSP.
REQ-015 SHALL assert cmd_ready only in IDLE; accept when cmd_valid and cmd_ready high on same clk.
REQ-016 On accept SHALL load cmd_data into 38-bit shift register, drive vji_ir_in=cmd_ir (held until next accept), enter UIR.
REQ-017 Each tck period SHALL be vji_tck low TCK_DIV clks then high TCK_DIV clks; vji_tck low in IDLE and RSP.
REQ-018 State flags (uir/cdr/sdr/udr/rti) SHALL be one-hot, change only on the clk where vji_tck goes low, and be low in IDLE/RSP.
REQ-019 UIR, CDR, UDR, RTI SHALL each last exactly 1 tck period; SHIFT exactly 38 periods.
REQ-020 In SHIFT, vji_tdi SHALL equal shift-register bit 0, updated at start of each period; vji_tdi=0 outside SHIFT.
REQ-021 On the clk where vji_tck rises in SHIFT, SHALL sample vji_tdo, shift right, insert sample at bit 37.
REQ-022 After RTI SHALL enter RSP with rsp_valid=1 and rsp_data=shift register, exactly 84*TCK_DIV clks after accept.
REQ-023 rsp_valid and rsp_data SHALL hold stable until rsp_valid and rsp_ready both high; then rsp_valid=0 and IDLE next clk.
REQ-024 SHALL not accept new command while rsp_valid high; back-to-back: cmd_ready high the clk after response handshake.
REQ-025 cmd_valid changes outside IDLE SHALL have no effect.

Reset
REQ-026 With reset_n low at clk edge: FSM=IDLE, all vji_* outputs 0, vji_ir_in=0, rsp_valid=0, rsp_data=0, tck divider=0, cmd_ready=0.
REQ-027 cmd_ready SHALL be 1 on first clk with reset_n high in IDLE.
REQ-028 Reset mid-scan SHALL abort immediately; no response produced for aborted command.

Configuration
REQ-029 Macro NIOS_DBG_JTAG_MASTER_LOOPBACK_EN: when defined, REQ-021 samples internal vji_tdi instead of vji_tdo (vji_tdo ignored), so rsp_data==cmd_data; when undefined, vji_tdo sampled as REQ-021.

Verification
REQ-030 TCK_DIV=1, LOOPBACK_EN defined, cmd_ir=2, cmd_data=0x15_5555_5555 -> vji_ir_in=2, rsp_valid at accept+84 clks, rsp_data=0x15_5555_5555.
REQ-031 TCK_DIV=2, macro undefined, vji_tdo tied 1, cmd_data=0 -> 38 sdr periods, vji_tdi always 0, rsp_data=0x3F_FFFF_FFFF at accept+168.
REQ-032 TCK_DIV=1, vji_tdo follows delayed copy set so first sample=1 rest 0 -> rsp_data=0x00_0000_0001; flags one-hot, order uir,cdr,sdr x38,udr,rti.
REQ-033 reset_n low 1 clk during SHIFT period 10 -> next clk all outputs 0, IDLE; then cmd_ready=1, no rsp_valid.
REQ-034 rsp_ready held 0 for 20 clks -> rsp_valid/rsp_data stable, cmd_ready 0, cmd_valid ignored; rsp_ready=1 -> IDLE next clk.
REQ-035 Two commands back-to-back with rsp_ready=1 -> second accepted clk after first response handshake, both responses correct.
